// File: rtl/cmd_cntrl_pkg.sv
// Shared types and field constants for the command/control sequencer.
package cmd_cntrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

    localparam logic [1:0] OP_GO      = 2'b01;
    localparam logic [1:0] OP_STOP    = 2'b00;
    localparam int         ID_W       = 6;
    localparam logic [1:0] STN_PREFIX = 2'b00;

endpackage

// File: rtl/cmd_cntrl_if.sv
// Valid/clear handshakes from the command receiver and the barcode reader.
interface cmd_cntrl_if;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;

    modport master (
        output cmd, cmd_rdy, ID, ID_vld,
        input  clr_cmd_rdy, clr_ID_vld
    );

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld,
        output clr_cmd_rdy, clr_ID_vld
    );
endinterface

// File: rtl/cmd_cntrl_buzz_gen.sv
// Obstacle buzzer: square wave with BUZZ_HALF clocks per half-period while enabled.
module buzz_gen #(
    parameter int BUZZ_HALF = 6250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);
    localparam int CNT_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buzz_q, buzz_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            buzz_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            buzz_q <= buzz_d;
        end
    end

    // Disabled: counter parks at 0 and the output is quiet.
    always_comb begin
        cnt_d  = '0;
        buzz_d = 1'b0;
        if (en) begin
            if (cnt_q == CNT_W'(BUZZ_HALF - 1)) begin
                cnt_d  = '0;
                buzz_d = ~buzz_q;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                buzz_d = buzz_q;
            end
        end
    end

    assign buzz   = buzz_q;
    assign buzz_n = ~buzz_q;
endmodule

// File: rtl/cmd_cntrl.sv
// Command/control sequencer: GO/STOP commands and barcode stations drive go/in_transit.
// Buzzer is built only when CMD_CNTRL_BUZZ_EN is defined.
module cmd_cntrl
    import cmd_cntrl_pkg::*;
#(
    parameter int BUZZ_HALF = 6250
) (
    input  logic              clk,
    input  logic              rst_n,
    cmd_cntrl_if.slave        bus,
    input  logic              OK2Move,
    output logic              go,
    output logic              in_transit,
    output logic              buzz,
    output logic              buzz_n
);
    state_t            state_q, state_d;
    logic [ID_W-1:0]   dest_id_q, dest_id_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dest_id_q <= '0;
        end else begin
            state_q   <= state_d;
            dest_id_q <= dest_id_d;
        end
    end

    // A pending command shadows the ID; the ID is judged next cycle against the new destination.
    always_comb begin
        state_d         = state_q;
        dest_id_d       = dest_id_q;
        bus.clr_cmd_rdy = 1'b0;
        bus.clr_ID_vld  = 1'b0;
        if (bus.cmd_rdy) begin
            bus.clr_cmd_rdy = 1'b1;
            if (bus.cmd[7:6] == OP_GO) begin
                dest_id_d = bus.cmd[ID_W-1:0];
                state_d   = TRANSIT;
            end else if (bus.cmd[7:6] == OP_STOP) begin
                state_d = IDLE;
            end
        end else if (bus.ID_vld) begin
            bus.clr_ID_vld = 1'b1;
            if ((state_q == TRANSIT) && (bus.ID[7:6] == STN_PREFIX) &&
                (bus.ID[ID_W-1:0] == dest_id_q))
                state_d = IDLE;
        end
    end

    assign in_transit = (state_q == TRANSIT);
    assign go         = in_transit & OK2Move;

`ifdef CMD_CNTRL_BUZZ_EN
    buzz_gen #(
        .BUZZ_HALF (BUZZ_HALF)
    ) u_buzz_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_transit & ~OK2Move),
        .buzz   (buzz),
        .buzz_n (buzz_n)
    );
`else
    logic buzz_half_unused;
    assign buzz_half_unused = (BUZZ_HALF > 0);
    assign buzz   = 1'b0;
    assign buzz_n = 1'b1;
`endif
endmodule
